// File: rtl/alert_sequencer_pkg.sv
// Shared types and default frame counts for the side-panel alert sequencer.
// No logic; the types and constants are used by the sequencer, its timer and its interface.
package alert_sequencer_pkg;

    typedef enum logic [1:0] {
        ALERT_IDLE       = 2'd0,
        ALERT_SHOW_TSPIN = 2'd1,
        ALERT_SHOW_LINES = 2'd2,
        ALERT_GAP        = 2'd3
    } alert_state_t;

    typedef logic [2:0] lines_cnt_t;

    localparam int ALERT_HOLD_FRAMES  = 120;
    localparam int ALERT_GAP_FRAMES   = 15;
    localparam int ALERT_BLINK_FRAMES = 8;

    // Terminal value for an up-counter that should fire on the frames-th tick.
    function automatic logic [7:0] frame_last(input int frames);
        return 8'(frames - 1);
    endfunction

endpackage

// File: rtl/alert_sequencer_if.sv
// Event inputs and alert-driver enables of the alert sequencer.
// Game logic drives the master side; the sequencer uses the slave side. No backpressure.
interface alert_sequencer_if;
    import alert_sequencer_pkg::*;

    logic       frame_start;
    logic       tspin_event;
    logic       lines_event;
    lines_cnt_t lines_count;
    logic       tspin_detected;
    logic       lines_alert;
    lines_cnt_t alert_lines;
    logic       busy;

    modport master (
        output frame_start, tspin_event, lines_event, lines_count,
        input  tspin_detected, lines_alert, alert_lines, busy
    );

    modport slave (
        input  frame_start, tspin_event, lines_event, lines_count,
        output tspin_detected, lines_alert, alert_lines, busy
    );
endinterface

// File: rtl/alert_sequencer_frame_timer.sv
// 8-bit frame counter: counts tick while en, wraps to 0 at last and flags done that cycle.
// Synchronous clr has priority over counting and suppresses done; no backpressure.
module alert_sequencer_frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] last,
    output logic       done
);
    logic [7:0] cnt;

    assign done = en && tick && !clr && (cnt == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en && tick) begin
            cnt <= (cnt == last) ? 8'd0 : cnt + 8'd1;
        end
    end
endmodule

// File: rtl/alert_sequencer.sv
// Schedules T-spin / line-clear alerts on one panel region; event -> enable in 1 cycle.
// No backpressure: events while busy are merged into pending flags. Blink via ALERT_BLINK_EN.
module alert_sequencer
    import alert_sequencer_pkg::*;
#(
    parameter int HOLD_FRAMES  = ALERT_HOLD_FRAMES,
`ifdef ALERT_BLINK_EN
    parameter int BLINK_FRAMES = ALERT_BLINK_FRAMES,
`endif
    parameter int GAP_FRAMES   = ALERT_GAP_FRAMES
) (
    input logic              clk,
    input logic              rst,
    alert_sequencer_if.slave alert
);
    localparam logic [1:0] IDLE       = ALERT_IDLE;
    localparam logic [1:0] SHOW_TSPIN = ALERT_SHOW_TSPIN;
    localparam logic [1:0] SHOW_LINES = ALERT_SHOW_LINES;
    localparam logic [1:0] GAP        = ALERT_GAP;
    localparam logic [7:0] HOLD_LAST  = frame_last(HOLD_FRAMES);
    localparam logic [7:0] GAP_LAST   = frame_last(GAP_FRAMES);
    localparam logic [1:0] HOLD_EXIT  = (GAP_FRAMES == 0) ? IDLE : GAP;

    logic [1:0] state, state_nxt;
    logic       tspin_pend, tspin_pend_nxt;
    logic       lines_pend, lines_pend_nxt;
    lines_cnt_t lines_pend_cnt, lines_pend_cnt_nxt;
    lines_cnt_t alert_lines_q, alert_lines_nxt;
    logic       lines_ok, in_show, retrig, timer_done, blank;

    // Line counts outside 1..4 are treated as a non-event.
    assign lines_ok = alert.lines_event && (alert.lines_count != 3'd0) && (alert.lines_count <= 3'd4);
    assign in_show  = (state == SHOW_TSPIN) || (state == SHOW_LINES);
    assign retrig   = ((state == SHOW_TSPIN) && alert.tspin_event) ||
                      ((state == SHOW_LINES) && lines_ok);

    alert_sequencer_frame_timer u_hold_gap (
        .clk  (clk),
        .rst  (rst),
        .tick (alert.frame_start),
        .en   (in_show || (state == GAP)),
        .clr  (retrig || (state == IDLE)),
        .last ((state == GAP) ? GAP_LAST : HOLD_LAST),
        .done (timer_done)
    );

    always_comb begin
        state_nxt          = state;
        tspin_pend_nxt     = tspin_pend;
        lines_pend_nxt     = lines_pend;
        lines_pend_cnt_nxt = lines_pend_cnt;
        alert_lines_nxt    = alert_lines_q;
        case (state)
            IDLE: begin
                if (tspin_pend || alert.tspin_event) begin
                    state_nxt      = SHOW_TSPIN;
                    tspin_pend_nxt = 1'b0;
                    if (lines_ok) begin
                        lines_pend_nxt     = 1'b1;
                        lines_pend_cnt_nxt = alert.lines_count;
                    end
                end else if (lines_pend || lines_ok) begin
                    state_nxt       = SHOW_LINES;
                    lines_pend_nxt  = 1'b0;
                    alert_lines_nxt = lines_ok ? alert.lines_count : lines_pend_cnt;
                end
            end
            SHOW_TSPIN: begin
                if (!alert.tspin_event && timer_done) state_nxt = HOLD_EXIT;
                if (lines_ok) begin
                    lines_pend_nxt     = 1'b1;
                    lines_pend_cnt_nxt = alert.lines_count;
                end
            end
            SHOW_LINES: begin
                if (lines_ok)        alert_lines_nxt = alert.lines_count;
                else if (timer_done) state_nxt       = HOLD_EXIT;
                if (alert.tspin_event) tspin_pend_nxt = 1'b1;
            end
            default: begin
                if (timer_done) state_nxt = IDLE;
                if (alert.tspin_event) tspin_pend_nxt = 1'b1;
                if (lines_ok) begin
                    lines_pend_nxt     = 1'b1;
                    lines_pend_cnt_nxt = alert.lines_count;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tspin_pend     <= 1'b0;
            lines_pend     <= 1'b0;
            lines_pend_cnt <= 3'd0;
            alert_lines_q  <= 3'd0;
        end else begin
            state          <= state_nxt;
            tspin_pend     <= tspin_pend_nxt;
            lines_pend     <= lines_pend_nxt;
            lines_pend_cnt <= lines_pend_cnt_nxt;
            alert_lines_q  <= alert_lines_nxt;
        end
    end

`ifdef ALERT_BLINK_EN
    localparam logic [7:0] BLINK_LAST = frame_last(BLINK_FRAMES);
    logic blink_done;

    alert_sequencer_frame_timer u_blink (
        .clk  (clk),
        .rst  (rst),
        .tick (alert.frame_start),
        .en   (in_show),
        .clr  (!in_show || retrig),
        .last (BLINK_LAST),
        .done (blink_done)
    );

    // Each alert starts in its visible phase; a retrigger restarts the blink too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    blank <= 1'b0;
        else if (!in_show || retrig) blank <= 1'b0;
        else if (blink_done)        blank <= ~blank;
    end
`else
    assign blank = 1'b0;
`endif

    assign alert.tspin_detected = (state == SHOW_TSPIN) && !blank;
    assign alert.lines_alert    = (state == SHOW_LINES) && !blank;
    assign alert.alert_lines    = alert_lines_q;
    assign alert.busy           = (state != IDLE) || tspin_pend || lines_pend;
endmodule

// File: tb/tb_alert_sequencer.sv
// Directed plus random stimulus for alert_sequencer against a frame-countdown reference model.
module tb_alert_sequencer;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
`ifdef ALERT_BLINK_EN
    localparam int BLINK = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alert_sequencer_if bus ();

`ifdef ALERT_BLINK_EN
    alert_sequencer #(.HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK), .GAP_FRAMES(GAP))
        dut (.clk(clk), .rst(rst), .alert(bus));
`else
    alert_sequencer #(.HOLD_FRAMES(HOLD), .GAP_FRAMES(GAP))
        dut (.clk(clk), .rst(rst), .alert(bus));
`endif

    always #5 clk = ~clk;

    // Reference model: which alert is on screen, frames left, gap frames left, pending work.
    int   m_cur;   // 0 none, 1 T-spin, 2 lines
    int   m_rem;
    int   m_gap;
    int   m_seen;
    bit   m_tp, m_lp;
    int   m_lc, m_al;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] obs();
        return {2'b00, bus.tspin_detected, bus.lines_alert, bus.alert_lines, bus.busy};
    endfunction

    function automatic logic [7:0] expv();
        bit vis;
`ifdef ALERT_BLINK_EN
        vis = ((m_seen / BLINK) % 2) == 0;
`else
        vis = 1'b1;
`endif
        return {2'b00, m_cur == 1 && vis, m_cur == 2 && vis, 3'(m_al),
                (m_cur != 0) || (m_gap > 0) || m_tp || m_lp};
    endfunction

    task automatic model_reset();
        m_cur = 0; m_rem = 0; m_gap = 0; m_seen = 0;
        m_tp = 0; m_lp = 0; m_lc = 0; m_al = 0;
    endtask

    task automatic model_step(input bit fs, input bit te, input bit le, input int lc);
        bit lv;
        lv = le && lc >= 1 && lc <= 4;
        if (m_cur == 1) begin
            if (te) begin m_rem = HOLD; m_seen = 0; end
            else if (fs) begin
                m_rem--; m_seen++;
                if (m_rem == 0) begin m_cur = 0; m_gap = GAP; end
            end
            if (lv) begin m_lp = 1; m_lc = lc; end
        end else if (m_cur == 2) begin
            if (lv) begin m_rem = HOLD; m_seen = 0; m_al = lc; end
            else if (fs) begin
                m_rem--; m_seen++;
                if (m_rem == 0) begin m_cur = 0; m_gap = GAP; end
            end
            if (te) m_tp = 1;
        end else if (m_gap > 0) begin
            if (fs) m_gap--;
            if (te) m_tp = 1;
            if (lv) begin m_lp = 1; m_lc = lc; end
        end else if (m_tp || te) begin
            m_cur = 1; m_rem = HOLD; m_seen = 0; m_tp = 0;
            if (lv) begin m_lp = 1; m_lc = lc; end
        end else if (m_lp || lv) begin
            m_cur = 2; m_rem = HOLD; m_seen = 0;
            m_al = lv ? lc : m_lc;
            m_lp = 0;
        end
    endtask

    // Called at a negedge: apply inputs for one posedge, then compare at the next negedge.
    task automatic step(input bit fs, input bit te, input bit le, input logic [2:0] lc);
        bus.frame_start = fs;
        bus.tspin_event = te;
        bus.lines_event = le;
        bus.lines_count = lc;
        @(posedge clk);
        model_step(fs, te, le, int'(lc));
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.tspin_event = 1'b0;
        bus.lines_event = 1'b0;
        bus.lines_count = 3'd0;
        chk("outs", obs(), expv());
    endtask

    task automatic run_frames(input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 3'd0);
            repeat (spacing) step(0, 0, 0, 3'd0);
        end
    endtask

    initial begin
        int         vis;
        logic [2:0] first_al;
        bit         got_al;

        bus.frame_start = 1'b0;
        bus.tspin_event = 1'b0;
        bus.lines_event = 1'b0;
        bus.lines_count = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset", obs(), 8'h00);
        rst = 1'b0;

        // Single T-spin alert, and a frame_start coincident with the event.
        step(0, 1, 0, 3'd0);
        run_frames(6, 2);
        step(1, 1, 0, 3'd0);
        run_frames(6, 1);

        // Invalid line counts are ignored.
        step(0, 0, 1, 3'd0);
        step(0, 0, 1, 3'd5);
        step(0, 0, 1, 3'd7);

        // Simultaneous events: T-spin first, lines (2) after the gap.
        step(0, 1, 1, 3'd2);
        run_frames(12, 2);

        // Retrigger after 3 frames extends visibility to 7 frames.
        step(0, 1, 0, 3'd0);
        vis = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.tspin_detected) vis++;
            step(1, 0, 0, 3'd0);
            step(0, 0, 0, 3'd0);
        end
        step(0, 1, 0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            if (bus.tspin_detected) vis++;
            step(1, 0, 0, 3'd0);
            step(0, 0, 0, 3'd0);
        end
`ifndef ALERT_BLINK_EN
        chk("retrig_vis", 8'(vis), 8'd7);
`endif

        // Two line events during T-spin merge into one alert showing 3.
        step(0, 1, 0, 3'd0);
        step(0, 0, 1, 3'd1);
        step(1, 0, 0, 3'd0);
        step(0, 0, 1, 3'd3);
        got_al = 1'b0;
        first_al = 3'd0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 3'd0);
            step(0, 0, 0, 3'd0);
            if (bus.lines_alert && !got_al) begin
                got_al = 1'b1;
                first_al = bus.alert_lines;
            end
        end
        chk("merged_cnt", {4'd0, got_al, first_al}, {4'd0, 1'b1, 3'd3});

        // Reset mid line alert with a T-spin pending.
        step(0, 0, 1, 3'd4);
        step(1, 0, 0, 3'd0);
        step(0, 1, 0, 3'd0);
        rst = 1'b1;
        #1;
        chk("rst_async", obs(), 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run_frames(8, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(2) == 0, $urandom_range(11) == 0,
                 $urandom_range(9) == 0, 3'($urandom_range(7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alert_sequencer.md
# alert_sequencer

Schedules on-screen game alerts ("TSPIN DETECTED", "N LINES CLEARED") onto the single shared alert region of the side panel. Captures one-cycle event pulses from game logic, holds each alert for a fixed number of VGA frames, separates back-to-back alerts with a blank gap, and arbitrates between the two requesters. Outputs feed the alert pixel drivers' enable inputs directly; only one alert is asserted at any time.

## Interface
- HOLD_FRAMES, 120, frames an alert stays visible (1..255)
- GAP_FRAMES, 15, blank frames between consecutive alerts (0..255)
- BLINK_FRAMES, 8, half-period of blink in frames (1..255; used only with ALERT_BLINK_EN)
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- frame_start  input  1  one-cycle pulse at start of each VGA frame
- tspin_event  input  1  one-cycle pulse: T-spin detected on piece lock
- lines_event  input  1  one-cycle pulse: lines cleared on piece lock
- lines_count  input  3  lines cleared (1..4), valid with lines_event
- tspin_detected  output  1  enable for T-spin alert driver
- lines_alert  output  1  enable for line-clear alert driver
- alert_lines  output  3  line count to display, stable while lines_alert
- busy  output  1  state != IDLE or any pending flag set

## Operation
- States: IDLE, SHOW_TSPIN, SHOW_LINES, GAP.
- Pending flags tspin_pend, lines_pend (+ lines_pend_cnt[2:0]) capture events; a repeated event of a pending source merges (count overwritten by newest).
- IDLE: tspin_pend -> SHOW_TSPIN (clears tspin_pend); else lines_pend -> SHOW_LINES (clears lines_pend, latches alert_lines). T-spin has fixed priority.
- Event arriving in IDLE with no pending: goes straight to SHOW_* next cycle without passing through a pending flag; simultaneous tspin_event and lines_event: SHOW_TSPIN, lines pending.
- SHOW_x: frame_cnt[7:0] increments on frame_start; when frame_start and frame_cnt == HOLD_FRAMES-1 -> GAP (or IDLE if GAP_FRAMES == 0), frame_cnt cleared.
- Retrigger: same-source event during its own SHOW_x resets frame_cnt to 0 (SHOW_LINES also updates alert_lines); other-source event sets its pending flag. No preemption.
- GAP: outputs low; frame_start and frame_cnt == GAP_FRAMES-1 -> IDLE. Events during GAP set pending.
- lines_count of 0 or >4 with lines_event: event ignored.
- Outputs decoded from registered state only: tspin_detected = (state == SHOW_TSPIN), lines_alert = (state == SHOW_LINES).

## Timing
- Reset: state IDLE, all flags and counters 0; tspin_detected 0, lines_alert 0, alert_lines 0, busy 0.
- Event at cycle N (IDLE) -> output high at N+1.
- Visible duration: from entry to HOLD_FRAMES-th frame_start inclusive; output drops the cycle after that frame_start.
- frame_start coincident with event in IDLE: that frame_start not counted.
- frame_start and same-source retrigger same cycle: retrigger wins, frame_cnt = 0.
- Reset mid-alert: outputs drop asynchronously; pending events discarded.

## Configuration
- ALERT_BLINK_EN defined: a blink_cnt counts frame_start in SHOW states; outputs are gated by a phase bit toggling every BLINK_FRAMES frames, starting visible on entry and reset to visible on retrigger. busy and timing unchanged.
- Not defined: outputs steady high for whole SHOW; no blink logic synthesized.

## Structure
- DisplayPkg gains: alert_state_t enum (IDLE, SHOW_TSPIN, SHOW_LINES, GAP), ALERT_HOLD_FRAMES, ALERT_GAP_FRAMES, ALERT_BLINK_FRAMES default constants.
- Sub-module frame_timer (frame_start-driven 8-bit counter with clear and terminal-count compare) instantiated once for hold/gap; a second instance for blink under ALERT_BLINK_EN.
- Top of display instantiates alert_sequencer and wires outputs to the alert pixel drivers.

## Test plan (HOLD_FRAMES=4, GAP_FRAMES=2, BLINK_FRAMES=1)
- tspin_event at idle -> tspin_detected high next cycle, low after 4th frame_start, busy low after 2 more frame_starts.
- tspin_event and lines_event (count 2) same cycle -> T-spin shown 4 frames, 2 blank frames, then lines_alert with alert_lines=2 for 4 frames.
- tspin_event again after 3 frame_starts of SHOW_TSPIN -> visible 4 further frames (7 total).
- lines_event count 1 then count 3 during SHOW_TSPIN -> single later line alert with alert_lines=3.
- rst asserted mid SHOW_LINES with tspin pending -> all outputs 0 immediately, no alert after release.
- ALERT_BLINK_EN, tspin_event -> tspin_detected pattern on, off, on, off per frame, then low.
